mmio_uart_tx: RTL

Memory-mapped UART transmitter that sits on the PicoRV32 native memory bus beside the RAM model, giving firmware a console output path. It decodes a 16-byte register window at BASE_ADDR, accepts bytes into a small FIFO, and serialises them 8N1 on `uart_tx`. The top level routes `mem_ready` and `mem_rdata` from this block or from the RAM using `sel`.

---
 rtl/mmio_uart_pkg.sv | 25 ++
 rtl/mmio_uart_tx_sync_fifo.sv | 63 ++++++
 rtl/mmio_uart_tx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register
// offsets (mem_addr[3:2]), STATUS bit positions and TX FSM state encodings.
package mmio_uart_pkg;

  // Register offsets, indexed by mem_addr[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS register fields
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_LVL_LSB = 8;

  // TX state machine encodings
  typedef logic [2:0] tx_state_t;
  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_START  = 3'd1;
  localparam tx_state_t ST_DATA   = 3'd2;
  localparam tx_state_t ST_PARITY = 3'd3;
  localparam tx_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock show-ahead FIFO. Push is ignored when full and pop is
// ignored when empty; full is taken from the registered level, so a push
// into a full FIFO is refused even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_wr, do_rd;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next pointer/level values from the qualified push and pop
  always_comb begin
    do_wr    = push && !full;
    do_rd    = pop && !empty;
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter on the PicoRV32 native bus: 16-byte
// register window (DATA/STATUS/DIV/reserved), TX FIFO and 8N1 serialiser.
// Optional feature: define MMIO_UART_TX_PARITY_EN to add an even parity bit
// between the data bits and the stop bit (11-bit frame).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        sel,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
);
  import mmio_uart_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic        accept, is_wr, data_wr;
  logic [1:0]  reg_off;
  logic [31:0] status_w;
  logic        unused_bits;

  // FIFO interface
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [LVL_W-1:0] fifo_level;

  // CSR / bus response registers
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ovf_q, ovf_d;
  logic [15:0] div_q, div_d;

  // TX engine registers
  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        frame_load;
`ifdef MMIO_UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  assign sel       = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign uart_tx   = tx_q;

  // Byte lanes and address bits the register map does not use
  assign unused_bits = ^{mem_wdata[31:16], mem_addr[1:0], mem_wstrb[3:2]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (mem_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Bus decode, STATUS assembly and CSR next-state / read data
  always_comb begin
    accept    = sel && !ready_q;
    is_wr     = |mem_wstrb;
    reg_off   = mem_addr[3:2];
    data_wr   = accept && is_wr && (reg_off == REG_DATA) && mem_wstrb[0];
    fifo_push = data_wr && !fifo_full;

    status_w                         = '0;
    status_w[STAT_BUSY]              = !fifo_empty || (state_q != ST_IDLE);
    status_w[STAT_FULL]              = fifo_full;
    status_w[STAT_OVF]               = ovf_q;
    status_w[STAT_LVL_LSB +: 8]      = 8'(fifo_level);

    ready_d = accept;
    rdata_d = '0;
    ovf_d   = ovf_q;
    div_d   = div_q;
    if (accept) begin
      if (is_wr) begin
        case (reg_off)
          REG_DATA:   if (mem_wstrb[0] && fifo_full) ovf_d = 1'b1;
          REG_STATUS: if (mem_wstrb[0] && mem_wdata[STAT_OVF]) ovf_d = 1'b0;
          REG_DIV: begin
            if (mem_wstrb[0]) div_d[7:0]  = mem_wdata[7:0];
            if (mem_wstrb[1]) div_d[15:8] = mem_wdata[15:8];
          end
          default: ;
        endcase
      end else begin
        case (reg_off)
          REG_STATUS: rdata_d = status_w;
          REG_DIV:    rdata_d = {16'h0000, div_q};
          default:    rdata_d = '0;
        endcase
      end
    end
  end

  // TX state machine: frame sequencing, bit timing and next serial level
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_lat_d  = div_lat_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    fifo_pop   = 1'b0;
    frame_load = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
    par_d      = par_q;
`endif

    if (state_q == ST_IDLE) begin
      frame_load = !fifo_empty;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      // Bit boundary: reload the period counter from the frame's divisor
      cnt_d = div_lat_q;
      case (state_q)
        ST_START: begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end
        ST_DATA: begin
          if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        ST_PARITY: state_d = ST_STOP;
`endif
        ST_STOP: begin
          // Chain straight into the next frame when more bytes are queued
          frame_load = !fifo_empty;
          if (fifo_empty) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Pop a byte and latch DIV so a mid-frame DIV write cannot stretch bits
    if (frame_load) begin
      fifo_pop  = 1'b1;
      state_d   = ST_START;
      div_lat_d = div_q;
      cnt_d     = div_q;
      shift_d   = fifo_dout;
`ifdef MMIO_UART_TX_PARITY_EN
      par_d     = ^fifo_dout;
`endif
    end

    // Output is registered from the next state so uart_tx is glitch-free
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
`ifdef MMIO_UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // Control registers: bus response, CSRs, FSM state and serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      div_q   <= DIV_RESET;
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      state_q <= state_d;
      tx_q    <= tx_d;
    end
  end

  // Datapath registers, always loaded before use at frame start
  always_ff @(posedge clk) begin
    cnt_q     <= cnt_d;
    div_lat_q <= div_lat_d;
    shift_q   <= shift_d;
    bit_idx_q <= bit_idx_d;
`ifdef MMIO_UART_TX_PARITY_EN
    par_q     <= par_d;
`endif
  end

endmodule
